// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of one single-port data memory between core (req 0) and debug/loader (req 1); req_*/rsp_* requester side, mem_* memory side, busy when not IDLE
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic              req_we0,
  input  logic              req_we1,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic rr, h_id, h_we, win, sel_we, mis;
  logic [ADDR_W-1:0] h_addr, sel_addr;
  logic [DATA_W-1:0] h_wdata, sel_wdata;
  always_comb begin
    win = &req_valid ? rr : req_valid[1];
    req_ready = (state == IDLE && |req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
    sel_we = win ? req_we1 : req_we0;
    sel_addr = win ? req_addr1 : req_addr0;
    sel_wdata = win ? req_wdata1 : req_wdata0;
    mis = |h_addr[1:0];
  end
  assign mem_addr = h_addr;
  assign mem_wd = h_wdata;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr <= 1'b0;
      h_id <= 1'b0;
      h_we <= 1'b0;
      h_addr <= '0;
      h_wdata <= '0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      mem_we <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          state <= ACCESS;
          h_id <= win;
          h_we <= sel_we;
          h_addr <= sel_addr;
          h_wdata <= sel_wdata;
          mem_we <= sel_we && sel_addr[1:0] == 2'b00;
        end
        ACCESS: begin
          state <= RESP;
          mem_we <= 1'b0;
          rsp_valid <= h_id ? 2'b10 : 2'b01;
          rsp_rdata <= (h_we || mis) ? '0 : mem_rd;
          rsp_err <= mis;
        end
        default: begin
          state <= IDLE;
          rsp_valid <= 2'b00;
          rr <= ~h_id;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors, corner sequences and randomized model check of dmem_arbiter
module tb_dmem_arbiter;
  logic clk = 1'b0, rst = 1'b0, frc = 1'b0;
  logic [1:0] valid = 2'b00, we = 2'b00;
  logic [1:0][31:0] addr = '0, wd = '0;
  logic [1:0] req_ready, rsp_valid;
  logic [31:0] rsp_rdata, mem_addr, mem_wd, mem_rd;
  logic rsp_err, mem_we, busy;
  int checks = 0, fails = 0;
  int left = 0;
  logic m_rr = 1'b0, m_id = 1'b0, m_we = 1'b0, win;
  logic [31:0] m_addr = '0, m_wd = '0;
  logic [1:0] acc = 2'b00, er;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mem_rd = frc ? 32'hDEADBEEF : f(mem_addr);
  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(valid), .req_ready(req_ready),
    .req_we0(we[0]), .req_we1(we[1]), .req_addr0(addr[0]), .req_addr1(addr[1]),
    .req_wdata0(wd[0]), .req_wdata1(wd[1]), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    left = 0;
    m_rr = 1'b0;
    acc = 2'b00;
  endtask

  typedef struct {
    logic [1:0] valid, we;
    logic [31:0] a0, a1, w0, w1;
    logic frc;
    logic [1:0] e_ready;
    logic e_we;
    logic [31:0] e_addr, e_wd, e_rdata;
    logic e_err;
  } vec_t;
  vec_t tv[6];

  initial begin
    tv[0] = '{2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 1'b1, 2'b01, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    tv[1] = '{2'b10, 2'b10, 32'h0, 32'h20, 32'h0, 32'h55, 1'b0, 2'b10, 1'b1, 32'h20, 32'h55, 32'h0, 1'b0};
    tv[2] = '{2'b01, 2'b01, 32'h13, 32'h0, 32'hAA, 32'h0, 1'b0, 2'b01, 1'b0, 32'h13, 32'hAA, 32'h0, 1'b1};
    tv[3] = '{2'b11, 2'b01, 32'h8, 32'h24, 32'h77, 32'h99, 1'b0, 2'b10, 1'b0, 32'h24, 32'h99, 32'h0024FFDB, 1'b0};
    tv[4] = '{2'b11, 2'b00, 32'h32, 32'h4, 32'h1, 32'h2, 1'b0, 2'b01, 1'b0, 32'h32, 32'h1, 32'h0, 1'b1};
    tv[5] = '{2'b10, 2'b00, 32'h0, 32'h3C, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h003CFFC3, 1'b0};
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wd", mem_wd, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid = tv[i].valid; we = tv[i].we; frc = tv[i].frc;
      addr[0] = tv[i].a0; addr[1] = tv[i].a1; wd[0] = tv[i].w0; wd[1] = tv[i].w1;
      @(negedge clk);
      chk("vec_ready", req_ready, tv[i].e_ready);
      chk("vec_idle_busy", busy, 0);
      cyc;
      valid = 2'b00; we = ~we; addr[0] += 32'h40; addr[1] += 32'h40; wd[0] = ~wd[0]; wd[1] = ~wd[1];
      @(negedge clk);
      chk("vec_mem_we", mem_we, tv[i].e_we);
      chk("vec_mem_addr", mem_addr, tv[i].e_addr);
      chk("vec_mem_wd", mem_wd, tv[i].e_wd);
      chk("vec_access_busy", busy, 1);
      chk("vec_access_ready", req_ready, 0);
      chk("vec_early_rsp", rsp_valid, 0);
      cyc;
      @(negedge clk);
      chk("vec_rsp_valid", rsp_valid, tv[i].e_ready);
      chk("vec_rdata", rsp_rdata, tv[i].e_rdata);
      chk("vec_err", rsp_err, tv[i].e_err);
      chk("vec_resp_mem_we", mem_we, 0);
      cyc;
      frc = 1'b0;
    end
    valid = 2'b11; we = 2'b00; addr[0] = 32'h4; addr[1] = 32'h8;
    do_reset;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("contend_rsp", rsp_valid, (k % 3 != 2) ? 2'b00 : (((k / 3) % 2) != 0 ? 2'b10 : 2'b01));
    end
    cyc;
    valid = 2'b00;
    cyc;
    valid = 2'b01; we = 2'b00; addr[0] = 32'h8;
    cyc;
    valid = 2'b00;
    cyc;
    cyc;
    valid = 2'b01; we = 2'b01; addr[0] = 32'h40; wd[0] = 32'h1234;
    cyc;
    valid = 2'b00;
    @(negedge clk);
    chk("abort_mem_we_pre", mem_we, 1);
    #1 rst = 1'b0;
    #1;
    chk("abort_mem_we", mem_we, 0);
    chk("abort_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
      chk("abort_idle", busy, 0);
    end
    cyc;
    valid = 2'b11; we = 2'b00;
    @(negedge clk);
    chk("abort_rr_cleared", req_ready, 2'b01);
    cyc;
    valid = 2'b00;
    cyc;
    cyc;
    valid = 2'b01; we = 2'b00; addr[0] = 32'h8;
    cyc;
    valid = 2'b10;
    cyc;
    valid = 2'b00;
    @(negedge clk);
    chk("withdraw_rsp0", rsp_valid, 2'b01);
    cyc;
    @(negedge clk);
    chk("withdraw_ready", req_ready, 0);
    chk("withdraw_rsp", rsp_valid, 0);
    cyc;
    @(negedge clk);
    chk("withdraw_idle", busy, 0);
    chk("withdraw_rsp2", rsp_valid, 0);
    valid = 2'b00;
    do_reset;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (valid[i] && !acc[i]) begin
          if ($urandom_range(0, 7) == 0) valid[i] = 1'b0;
        end else begin
          valid[i] = 1'($urandom_range(0, 1));
          we[i] = 1'($urandom_range(0, 1));
          addr[i] = 32'($urandom_range(0, 15)) * 4 + ($urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 3)) : 32'h0);
          wd[i] = $urandom;
        end
      end
      @(negedge clk);
      win = (valid == 2'b11) ? m_rr : valid[1];
      er = (left == 0 && |valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
      chk("rnd_ready", req_ready, er);
      chk("rnd_busy", busy, left != 0);
      chk("rnd_mem_we", mem_we, left == 2 && m_we && m_addr[1:0] == 2'b00);
      chk("rnd_rsp_valid", rsp_valid, left == 1 ? (m_id ? 2'b10 : 2'b01) : 2'b00);
      if (left == 2) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        chk("rnd_mem_wd", mem_wd, m_wd);
      end
      if (left == 1) begin
        chk("rnd_rdata", rsp_rdata, (m_we || m_addr[1:0] != 2'b00) ? 32'h0 : f(m_addr));
        chk("rnd_err", rsp_err, m_addr[1:0] != 2'b00);
      end
      if (left == 0 && |valid) begin
        m_id = win; m_we = we[win]; m_addr = addr[win]; m_wd = wd[win];
        left = 2;
      end else if (left == 2) begin
        left = 1;
      end else if (left == 1) begin
        left = 0;
        m_rr = ~m_id;
      end
      acc = er;
      cyc;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
